logic_wave_scope: RTL
=====================

# logic_wave_scope

Parametrised, buffered successor to the 4-channel stripe pixel generator. It captures `NCH`-bit logic samples into a circular buffer and supports free-run, single-shot trigger and hold modes. It answers pipelined pixel requests from the OLED scan driver with RGB565 colours: per-channel lanes, drawn high/low traces, transition edges and a trigger marker. It sits between the sample front-end and the display driver.

## Interface
- `NCH`, 4: channel count. Colour for channel k is palette[k mod 4] = F800, 07E0, 001F, FFE0.
- `WIDTH`, 96: display width in pixels.
- `HEIGHT`, 64: display height in pixels. Must be divisible by `NCH`. `LANE_H` = `HEIGHT`/`NCH`, which must be at least 6.
- `LABEL_W`, 8: label-zone width. `DEPTH` = `WIDTH`−`LABEL_W` samples. `PRE` = `DEPTH`/2 pre-trigger samples.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample` in `NCH`: logic sample.
- `sample_valid` in 1: strobe that writes `sample` this cycle.
- `mode` in 2: 0 = RUN, 1 = SINGLE, 2 = HOLD. Value 3 is treated as HOLD.
- `trig_mask`, `trig_val` in `NCH`: trigger match = ((`sample`^`trig_val`)&`trig_mask`)==0.
- `rearm` in 1: pulse that restarts a single-shot capture.
- `pix_req` in 1: pixel request strobe.
- `x` in clog2(`WIDTH`), `y` in clog2(`HEIGHT`): request coordinates.
- `pix_valid` out 1: response valid.
- `pix_color` out 16: RGB565 colour.
- `frozen` out 1: high in FROZEN or HOLD.
- `state` out 2: 0 = RUN, 1 = ARMED, 2 = POST, 3 = FROZEN. HOLD reports 3.

## Operation
- The buffer has `DEPTH` entries of 2·`NCH` bits: the level, plus a transition flag per channel (level XOR previous written level).
- The first write after reset or `rearm` has all transition flags 0.
- `wr_ptr` wraps from `DEPTH`−1 to 0.
- `fill` saturates at `DEPTH`.
- Writes occur only in RUN, ARMED and POST.
- FSM, with `mode` evaluated every cycle:
  - `mode`=0 forces RUN.
  - `mode`≥2 holds: no writes, `state` reads 3.
  - `mode`=1 while in RUN moves to ARMED with `fill` cleared.
  - ARMED → POST on a write where match is true, the previous written sample did not match, and `fill`≥`PRE`. That trigger sample is written, and the post counter loads `DEPTH`−`PRE`−1.
  - POST decrements the counter per write. The write at count 0 moves to FROZEN.
  - FROZEN ignores `sample_valid`.
  - `rearm` in FROZEN or POST → ARMED. It clears `fill` and the match history.
  - `rearm` and `sample_valid` in the same cycle: `rearm` wins and the sample is dropped.
- Column mapping: c = `x`−`LABEL_W`. The column has data iff c ≥ `DEPTH`−`fill`. Index = (`wr_ptr`+c) mod `DEPTH`. The newest sample is at `x`=`WIDTH`−1.
- Lane and row: lane = `y`/`LANE_H`, r = `y` mod `LANE_H`. `HIGH_R` = 2, `LOW_R` = `LANE_H`−3.
- Colour priority, first match wins:
  - `x` < `LABEL_W`: lane colour.
  - Column with no data: 0000.
  - Trace lit gives lane colour. Lit means (level high and r=`HIGH_R`), or (level low and r=`LOW_R`), or (transition and `HIGH_R`≤r≤`LOW_R`).
  - In FROZEN after a trigger, with c=`PRE` and `y` even: FFFF.
  - Otherwise 0000.
- The trigger marker stays off in HOLD entered from RUN.
- Reads return data from before any same-cycle write to the same entry.

## Timing
- Reset values: `pix_valid`=0, `pix_color`=0000, `frozen`=0, `state`=RUN, `wr_ptr`=0, `fill`=0, match history 0. Buffer contents don't care.
- Pixel pipeline has a fixed 2-cycle latency. A request in cycle n gives `pix_valid`=1 and its colour in cycle n+2.
- Throughput is one request per cycle with no stall. `pix_valid` is 0 when no request is in flight.
- Capture state (`state`, `fill`, `wr_ptr`) updates on the edge that samples the strobe.
- A request issued in the same cycle as a write sees the pre-write `fill` and `wr_ptr`.
- Asserting `rst_n` mid-POST aborts the capture. All outputs return to their reset values asynchronously.

## Test plan
- **Reset and empty buffer.** Reset, then RUN. Request `x`=50, `y`=2 → `pix_valid` at +2, `pix_color`=0000. Request `x`=3, `y`=40 → 001F. `frozen`=0.
- **RUN scroll and transitions.** Write 88 samples of 0x0, then 0x1. Then:
  - `x`=95, `y`=2 → F800; `y`=8 → F800; `y`=29 → 07E0.
  - `x`=94, `y`=2 → 0000; `y`=13 → F800.
- **SINGLE trigger.** `trig_mask`=1, `trig_val`=1. Write 60×0x0, then 0x1, then 43×0x1 → `state` ARMED→POST→FROZEN and `frozen`=1 after the 43rd post write. Then:
  - Further writes leave `wr_ptr` unchanged.
  - `x`=52, `y`=8 → F800.
  - `x`=52, `y`=20 → FFFF.
  - `x`=52, `y`=21 → 0000.
- **Early match ignored.** After `rearm`, write 10×0x0, then 0x1 while `fill`=10 → stays ARMED. Hold level 1 → no trigger until a 0→1 match edge at `fill`≥44.
- **Simultaneous events and pipelining.** `rearm` with `sample_valid` in FROZEN → ARMED, `fill`=0, sample dropped. Back-to-back `pix_req` for `x`=0..95 → 96 consecutive valid responses, in order, each 2 cycles later.
- **Reset mid-POST.** Pull `rst_n` low during POST → immediately `state`=RUN, `frozen`=0, `pix_valid`=0. After release, any data column request → 0000.

Source files
------------

// File: rtl/logic_wave_scope.sv
// Buffered multi-channel logic scope: captures samples into a circular buffer with
// run / single-shot / hold capture and renders RGB565 pixels for the OLED scan driver.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_RUN    | free-running capture, buffer scrolls continuously
// S_ARMED  | single-shot armed, filling pre-trigger history
// S_POST   | trigger seen, capturing the post-trigger samples
// S_FROZEN | capture complete, buffer contents held for display
module logic_wave_scope #(
  parameter int NCH     = 4,
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 64,
  parameter int LABEL_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NCH-1:0]            sample,
  input  logic                      sample_valid,
  input  logic [1:0]                mode,
  input  logic [NCH-1:0]            trig_mask,
  input  logic [NCH-1:0]            trig_val,
  input  logic                      rearm,
  input  logic                      pix_req,
  input  logic [$clog2(WIDTH)-1:0]  x,
  input  logic [$clog2(HEIGHT)-1:0] y,
  output logic                      pix_valid,
  output logic [15:0]               pix_color,
  output logic                      frozen,
  output logic [1:0]                state
);

  localparam int DEPTH  = WIDTH - LABEL_W;
  localparam int PRE    = DEPTH / 2;
  localparam int LANE_H = HEIGHT / NCH;
  localparam int HIGH_R = 2;
  localparam int LOW_R  = LANE_H - 3;
  localparam int XW     = $clog2(WIDTH);
  localparam int PW     = $clog2(DEPTH);
  localparam int FW     = $clog2(DEPTH + 1);
  localparam int CW     = XW + 1;
  localparam int RW     = $clog2(LANE_H);
  localparam int LW     = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_ARMED  = 2'd1,
    S_POST   = 2'd2,
    S_FROZEN = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [PW-1:0]    wr_ptr, wr_ptr_n;
  logic [FW-1:0]    fill, fill_n;
  logic [PW-1:0]    post_cnt, post_cnt_n;
  logic             prev_match, prev_match_n;
  logic             first_wr, first_wr_n;
  logic             trig_seen, trig_seen_n;
  logic [NCH-1:0]   prev_lvl, prev_lvl_n;
  logic             we, hold, match;
  logic [2*NCH-1:0] wr_data;
  logic [2*NCH-1:0] mem [DEPTH];

  assign hold    = mode[1];
  assign match   = ((sample ^ trig_val) & trig_mask) == '0;
  assign wr_data = {({NCH{~first_wr}} & (sample ^ prev_lvl)), sample};
  assign state   = hold ? 2'd3 : state_q;
  assign frozen  = hold || (state_q == S_FROZEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      wr_ptr     <= '0;
      fill       <= '0;
      post_cnt   <= '0;
      prev_match <= 1'b0;
      first_wr   <= 1'b1;
      trig_seen  <= 1'b0;
      prev_lvl   <= '0;
    end else begin
      state_q    <= state_n;
      wr_ptr     <= wr_ptr_n;
      fill       <= fill_n;
      post_cnt   <= post_cnt_n;
      prev_match <= prev_match_n;
      first_wr   <= first_wr_n;
      trig_seen  <= trig_seen_n;
      prev_lvl   <= prev_lvl_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    wr_ptr_n     = wr_ptr;
    fill_n       = fill;
    post_cnt_n   = post_cnt;
    prev_match_n = prev_match;
    first_wr_n   = first_wr;
    trig_seen_n  = trig_seen;
    prev_lvl_n   = prev_lvl;
    we           = 1'b0;
    if (mode == 2'd0) begin
      state_n     = S_RUN;
      trig_seen_n = 1'b0;
      we          = sample_valid;
    end else if (!hold) begin
      case (state_q)
        S_RUN: begin
          state_n = S_ARMED;
          fill_n  = '0;
        end
        S_ARMED: begin
          if (sample_valid) begin
            we = 1'b1;
            if (match && !prev_match && fill >= FW'(PRE)) begin
              state_n     = S_POST;
              post_cnt_n  = PW'(DEPTH - PRE - 1);
              trig_seen_n = 1'b1;
            end
          end
        end
        default: begin
          // rearm beats a same-cycle sample: the sample is dropped
          if (rearm) begin
            state_n      = S_ARMED;
            fill_n       = '0;
            prev_match_n = 1'b0;
            first_wr_n   = 1'b1;
            trig_seen_n  = 1'b0;
          end else if (sample_valid && state_q == S_POST) begin
            we = 1'b1;
            if (post_cnt <= PW'(1)) state_n = S_FROZEN;
            else post_cnt_n = post_cnt - 1'b1;
          end
        end
      endcase
    end
    if (we) begin
      wr_ptr_n     = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (fill != FW'(DEPTH)) fill_n = fill + 1'b1;
      prev_match_n = match;
      prev_lvl_n   = sample;
      first_wr_n   = 1'b0;
    end
  end

  // Pixel stage 1: decode coordinates against pre-write capture state
  logic [CW-1:0]    col, rd_sum;
  logic [PW-1:0]    rd_idx;
  logic [2*NCH-1:0] rd_q;
  logic             v1, label1, data1, mark1;
  logic [LW-1:0]    lane1;
  logic [RW-1:0]    r1;

  assign col    = CW'(x) - CW'(LABEL_W);
  assign rd_sum = CW'(wr_ptr) + col;
  assign rd_idx = PW'((rd_sum >= CW'(DEPTH)) ? rd_sum - CW'(DEPTH) : rd_sum);

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wr_data;
    rd_q <= mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      label1 <= 1'b0;
      data1  <= 1'b0;
      mark1  <= 1'b0;
      lane1  <= '0;
      r1     <= '0;
    end else begin
      v1     <= pix_req;
      label1 <= x < XW'(LABEL_W);
      data1  <= (CW'(fill) + col) >= CW'(DEPTH);
      mark1  <= trig_seen && frozen && (col == CW'(PRE)) && !y[0];
      lane1  <= LW'(int'(y) / LANE_H);
      r1     <= RW'(int'(y) % LANE_H);
    end
  end

  // Pixel stage 2: trace rendering and colour priority
  function automatic logic [15:0] pal(input logic [LW-1:0] k);
    case (2'(k))
      2'd0:    return 16'hF800;
      2'd1:    return 16'h07E0;
      2'd2:    return 16'h001F;
      default: return 16'hFFE0;
    endcase
  endfunction

  logic [NCH-1:0] lvl_vec, tr_vec;
  logic           lvl, tr, lit;
  logic [15:0]    color_n;

  assign lvl_vec = rd_q[NCH-1:0];
  assign tr_vec  = rd_q[2*NCH-1:NCH];
  assign lvl     = lvl_vec[lane1];
  assign tr      = tr_vec[lane1];
  assign lit     = (lvl && r1 == RW'(HIGH_R)) || (!lvl && r1 == RW'(LOW_R)) ||
                   (tr && r1 >= RW'(HIGH_R) && r1 <= RW'(LOW_R));

  always_comb begin
    color_n = 16'h0000;
    if (label1)      color_n = pal(lane1);
    else if (!data1) color_n = 16'h0000;
    else if (lit)    color_n = pal(lane1);
    else if (mark1)  color_n = 16'hFFFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_color <= 16'h0000;
    end else begin
      pix_valid <= v1;
      if (v1) pix_color <= color_n;
    end
  end

endmodule
